pipelined_adder: RTL and testbench
==================================

# pipelined_adder

Parametrised, pipelined add/subtract unit that generalises the team's fixed 8-bit carry-chain adder to WIDTH bits. The carry chain is cut into SEG-bit segments, one segment resolved per pipeline stage, so the critical path stays one segment long at any width. A valid/ready handshake on both sides lets the block sit directly in streaming datapaths between producers and consumers that can apply backpressure. Results include carry/borrow-out and signed overflow.

## Interface
- WIDTH, default 32: operand and result width; must be a multiple of SEG (elaboration error otherwise)
- SEG, default 4: bits resolved per pipeline stage; STAGES = WIDTH/SEG is the latency
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand bundle valid
- in_ready  output  1  block can accept a bundle this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (ADD) / borrow-in (SUB, active-high)
- op  input  1  adder_pkg::op_e: OP_ADD=0, OP_SUB=1
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry-out (ADD) / not-borrow (SUB)
- ovf  output  1  two's-complement signed overflow

## Operation
- Effective operation: sum = a + (op ? ~b : b) + (op ? ~cin : cin), i.e. ADD: a+b+cin; SUB: a−b−cin. All arithmetic modulo 2^WIDTH.
- cout = carry out of bit WIDTH−1 of that sum; ovf = carry into bit WIDTH−1 XOR cout.
- Stage k (0..STAGES−1) computes bits [k*SEG +: SEG] from registered carry of stage k−1 (stage 0 uses effective carry-in). Unprocessed operand segments travel forward in skew registers; finished sum segments travel forward to the output.
- Each stage holds a valid bit; a bubble propagates as valid=0 and its data is don't-care.
- Transfer in: in_valid && in_ready at a clock edge. Transfer out: out_valid && out_ready.
- Stall: stall = out_valid && !out_ready. When stall=1 every stage register holds; in_ready = !stall. No bubble-collapsing required.
- No reordering: results emerge in acceptance order.
- op and cin are sampled only on transfer-in; changes on non-transfer cycles are ignored.

## Timing
- Latency: bundle accepted at edge n appears with out_valid=1 after edge n+STAGES−1 (visible in cycle n+STAGES), absent stalls. Each stall cycle adds one cycle.
- Throughput: one result per cycle when out_ready held high.
- in_ready is combinational from out_valid and out_ready only (never from in_valid).
- out_valid, sum, cout, ovf are registered outputs; stable while stall=1.
- Reset: on any edge with rst=1, all stage valid bits clear; out_valid=0, sum=0, cout=0, ovf=0; in_ready=1 in the following cycle. In-flight bundles are dropped, no partial result is emitted. rst overrides a simultaneous transfer-in.
- Simultaneous transfer-out and transfer-in in the same cycle: both occur; pipeline advances one slot.
- STAGES=1 (SEG=WIDTH): behaves as a single registered adder, latency 1.

## Structure
- adder_pkg: op_e typedef (OP_ADD, OP_SUB), default WIDTH/SEG constants.
- Sub-module adder_stage: one SEG-bit segment add with registered sum segment, carry, carry-into-MSB (used by last stage for ovf), valid, and enable (=!stall). Top level generates STAGES instances plus skew/alignment registers.

## Test plan
- WIDTH=32, SEG=4, out_ready=1: a=0xFFFF_FFFF, b=1, cin=0, ADD -> after 8 cycles sum=0, cout=1, ovf=0 (carry ripples through all stages).
- ADD a=0x7FFF_FFFF, b=1 -> sum=0x8000_0000, cout=0, ovf=1; SUB a=0x8000_0000, b=1, cin=0 -> sum=0x7FFF_FFFF, cout=1, ovf=1.
- SUB a=5, b=7, cin=1 -> sum=0xFFFF_FFFD, cout=0, ovf=0.
- Back-to-back 100 random bundles, out_ready=1 -> one result per cycle, in order, matching reference model.
- Random out_ready toggling (~50%) with continuous in_valid -> no loss/duplication; outputs stable during stall; in_ready=0 exactly when out_valid&&!out_ready.
- Fill pipeline, assert rst one cycle mid-stream -> next cycle out_valid=0, sum=0, in_ready=1; no pre-reset results ever appear.

Source files
------------

// File: rtl/adder_pkg.sv
// adder_pkg: shared types and default geometry for the pipelined add/subtract unit.
//   op_e         operation select (OP_ADD / OP_SUB)
//   DefaultWidth default operand/result width
//   DefaultSeg   default bits resolved per pipeline stage
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    localparam int unsigned DefaultWidth = 32;
    localparam int unsigned DefaultSeg   = 4;

endpackage

// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: operand/result streaming bundle for pipelined_adder.
//   Input side : in_valid, in_ready, a, b, cin, op
//   Output side: out_valid, out_ready, sum, cout, ovf
//   slave  modport: the adder's view
//   master modport: the producer/consumer view
interface pipelined_adder_if #(
    parameter int unsigned WIDTH = adder_pkg::DefaultWidth
);
    import adder_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    op_e              op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport slave (
        input  in_valid, a, b, cin, op, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

    modport master (
        output in_valid, a, b, cin, op, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/adder_stage.sv
// adder_stage: one SEG-bit slice of the carry chain, registered.
//   clk, rst   clock, synchronous active-high reset
//   en_i       advance enable (low while the pipeline is stalled)
//   valid_i    incoming slot valid
//   a_i, b_i   operand segment (b already inverted for subtract)
//   c_i        carry into this segment
//   valid_o    registered slot valid
//   sum_o      registered sum segment
//   c_o        registered carry out of the segment
//   cmsb_o     registered carry into the segment MSB (signed overflow on the last stage)
module adder_stage #(
    parameter int unsigned SEG = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en_i,
    input  logic           valid_i,
    input  logic [SEG-1:0] a_i,
    input  logic [SEG-1:0] b_i,
    input  logic           c_i,
    output logic           valid_o,
    output logic [SEG-1:0] sum_o,
    output logic           c_o,
    output logic           cmsb_o
);
    logic [SEG:0]   full_d;
    logic           cmsb_d;
    logic           valid_q;
    logic [SEG-1:0] sum_q;
    logic           c_q;
    logic           cmsb_q;

    always_comb begin
        full_d = {1'b0, a_i} + {1'b0, b_i} + {{SEG{1'b0}}, c_i};
        // Carry into the MSB recovered from the MSB sum bit and its operands.
        cmsb_d = full_d[SEG-1] ^ a_i[SEG-1] ^ b_i[SEG-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            cmsb_q  <= 1'b0;
        end else if (en_i) begin
            valid_q <= valid_i;
            sum_q   <= full_d[SEG-1:0];
            c_q     <= full_d[SEG];
            cmsb_q  <= cmsb_d;
        end
    end

    assign valid_o = valid_q;
    assign sum_o   = sum_q;
    assign c_o     = c_q;
    assign cmsb_o  = cmsb_q;

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract with the carry chain cut into SEG-bit stages.
//   clk, rst  clock, synchronous active-high reset
//   io        pipelined_adder_if.slave: valid/ready operand input, valid/ready result output
// Latency is WIDTH/SEG cycles; the whole pipeline freezes while the output is stalled.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned SEG   = DefaultSeg
) (
    input  logic             clk,
    input  logic             rst,
    pipelined_adder_if.slave io
);
    localparam int unsigned STAGES = WIDTH / SEG;
    localparam int unsigned LAST   = STAGES - 1;

    if ((WIDTH % SEG) != 0) begin : g_bad_seg
        $error("pipelined_adder: WIDTH must be a multiple of SEG");
    end

    logic             stall;
    logic             en;

    // Per-stage inputs. Operands shift right by SEG each stage so every stage consumes
    // bits [SEG-1:0]; the result shifts right with each new segment entering at the top.
    logic [WIDTH-1:0] a_in   [STAGES];
    logic [WIDTH-1:0] b_in   [STAGES];
    logic [WIDTH-1:0] res_in [STAGES];
    logic             c_in   [STAGES];
    logic             v_in   [STAGES];

    // Per-stage registered state.
    logic [WIDTH-1:0] a_q    [STAGES];
    logic [WIDTH-1:0] b_q    [STAGES];
    logic [WIDTH-1:0] res_q  [STAGES];
    logic [SEG-1:0]   seg_q  [STAGES];
    logic             c_q    [STAGES];
    logic             cmsb_q [STAGES];
    logic             v_q    [STAGES];

    assign stall       = v_q[LAST] && !io.out_ready;
    assign en          = !stall;
    assign io.in_ready = !stall;

    always_comb begin
        a_in[0]   = io.a;
        b_in[0]   = (io.op == OP_SUB) ? ~io.b : io.b;
        c_in[0]   = io.cin ^ (io.op == OP_SUB);
        v_in[0]   = io.in_valid;
        res_in[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k]   = a_q[k-1];
            b_in[k]   = b_q[k-1];
            c_in[k]   = c_q[k-1];
            v_in[k]   = v_q[k-1];
            res_in[k] = res_q[k-1] | (WIDTH'(seg_q[k-1]) << (WIDTH - SEG));
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_stage #(
            .SEG (SEG)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en_i    (en),
            .valid_i (v_in[k]),
            .a_i     (a_in[k][SEG-1:0]),
            .b_i     (b_in[k][SEG-1:0]),
            .c_i     (c_in[k]),
            .valid_o (v_q[k]),
            .sum_o   (seg_q[k]),
            .c_o     (c_q[k]),
            .cmsb_o  (cmsb_q[k])
        );
    end

    // Operand skew registers carry only don't-care data for bubbles, so no reset.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_in[k] >> SEG;
                b_q[k] <= b_in[k] >> SEG;
            end
        end
    end

    // Finished-segment alignment registers are reset so sum reads zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                res_q[k] <= '0;
            end
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                res_q[k] <= res_in[k] >> SEG;
            end
        end
    end

    assign io.out_valid = v_q[LAST];
    assign io.sum       = res_q[LAST] | (WIDTH'(seg_q[LAST]) << (WIDTH - SEG));
    assign io.cout      = c_q[LAST];
    assign io.ovf       = cmsb_q[LAST] ^ c_q[LAST];

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed and randomised checks of pipelined_adder (WIDTH=32, SEG=4)
// against a scoreboard fed by an independent arithmetic model.
module tb_pipelined_adder;
    import adder_pkg::*;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned SEG    = 4;
    localparam int unsigned STAGES = WIDTH / SEG;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;
    int n_in     = 0;
    int n_out    = 0;

    logic [33:0] sb [$];
    logic        stall_prev = 1'b0;
    logic [34:0] held;

    pipelined_adder_if #(.WIDTH(WIDTH)) io ();

    pipelined_adder #(
        .WIDTH (WIDTH),
        .SEG   (SEG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {cout, ovf, sum} using wide arithmetic and the sign rule for overflow.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input op_e op);
        logic [32:0] full;
        logic [31:0] bb;
        logic        cc;
        logic        v;
        bb   = (op == OP_SUB) ? ~b : b;
        cc   = (op == OP_SUB) ? !cin : cin;
        full = {1'b0, a} + {1'b0, bb} + {32'd0, cc};
        v    = (a[31] == bb[31]) && (full[31] != a[31]);
        return {full[32], v, full[31:0]};
    endfunction

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            stall_prev <= 1'b0;
        end else begin
            check("in_ready", {63'd0, io.in_ready}, {63'd0, !(io.out_valid && !io.out_ready)});
            if (stall_prev) begin
                check("stall_hold", {29'd0, io.out_valid, io.cout, io.ovf, io.sum}, {29'd0, held});
            end
            if (io.out_valid && io.out_ready) begin
                check("no_spurious", {63'd0, sb.size() != 0}, 64'd1);
                if (sb.size() != 0) begin
                    check("result", {30'd0, io.cout, io.ovf, io.sum}, {30'd0, sb.pop_front()});
                    n_out <= n_out + 1;
                end
            end
            if (io.in_valid && io.in_ready) begin
                sb.push_back(model(io.a, io.b, io.cin, io.op));
                n_in <= n_in + 1;
            end
            stall_prev <= io.out_valid && !io.out_ready;
            held       <= {io.out_valid, io.cout, io.ovf, io.sum};
        end
    end

    task automatic drive_random();
        io.a        = $urandom;
        io.b        = $urandom;
        io.cin      = 1'($urandom_range(0, 1));
        io.op       = op_e'($urandom_range(0, 1));
        io.in_valid = 1'b1;
    endtask

    // One isolated bundle: checks latency and the expected result constants.
    task automatic send_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic cin, input op_e op, input logic [31:0] exp_sum,
                            input logic exp_cout, input logic exp_ovf);
        int cnt;
        @(posedge clk); #1;
        io.a = a; io.b = b; io.cin = cin; io.op = op; io.in_valid = 1'b1;
        @(posedge clk); #1;
        // Scramble op/cin after acceptance; they must not affect the result.
        io.in_valid = 1'b0;
        io.cin      = !cin;
        io.op       = (op == OP_ADD) ? OP_SUB : OP_ADD;
        cnt = 1;
        forever begin
            @(negedge clk);
            if (io.out_valid || cnt >= 20) break;
            @(posedge clk); #1;
            cnt++;
        end
        check({tag, "_latency"}, 64'(cnt), 64'(STAGES));
        check({tag, "_sum"}, {32'd0, io.sum}, {32'd0, exp_sum});
        check({tag, "_cout"}, {63'd0, io.cout}, {63'd0, exp_cout});
        check({tag, "_ovf"}, {63'd0, io.ovf}, {63'd0, exp_ovf});
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int last;
        int cnt;
        int start_in;
        int start_out;

        rst          = 1'b1;
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        io.a         = '0;
        io.b         = '0;
        io.cin       = 1'b0;
        io.op        = OP_ADD;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", {63'd0, io.out_valid}, 64'd0);
        check("reset_sum", {32'd0, io.sum}, 64'd0);
        check("reset_cout", {63'd0, io.cout}, 64'd0);
        check("reset_ovf", {63'd0, io.ovf}, 64'd0);
        check("reset_in_ready", {63'd0, io.in_ready}, 64'd1);

        // Directed corner cases.
        send_one("ripple", 32'hFFFF_FFFF, 32'h1, 1'b0, OP_ADD, 32'h0, 1'b1, 1'b0);
        send_one("add_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, OP_ADD, 32'h8000_0000, 1'b0, 1'b1);
        send_one("sub_ovf", 32'h8000_0000, 32'h1, 1'b0, OP_SUB, 32'h7FFF_FFFF, 1'b1, 1'b1);
        send_one("sub_borrow", 32'h5, 32'h7, 1'b1, OP_SUB, 32'hFFFF_FFFD, 1'b0, 1'b0);

        // Back-to-back 100 bundles, consumer always ready.
        first = -1; last = -1; cnt = 0;
        for (int i = 0; i < 100 + STAGES + 4; i++) begin
            @(posedge clk); #1;
            if (i < 100) drive_random();
            else io.in_valid = 1'b0;
            @(negedge clk);
            if (io.out_valid) begin
                if (first < 0) first = i;
                last = i;
                cnt++;
            end
        end
        check("b2b_count", 64'(cnt), 64'd100);
        check("b2b_span", 64'(last - first + 1), 64'd100);

        // Continuous input with random backpressure.
        start_in  = n_in;
        start_out = n_out;
        for (int c = 0; c < 3000 && (n_in - start_in) < 100; c++) begin
            @(posedge clk); #1;
            drive_random();
            io.out_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        for (int c = 0; c < 40 && sb.size() != 0; c++) @(negedge clk);
        @(posedge clk); #1;
        check("stall_accepted", {63'd0, (n_in - start_in) >= 100}, 64'd1);
        check("stall_drained", 64'(sb.size()), 64'd0);
        check("stall_in_out", 64'(n_out - start_out), 64'(n_in - start_in));

        // Reset mid-stream with a bundle offered on the reset edge.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            drive_random();
        end
        @(posedge clk); #1;
        drive_random();
        rst = 1'b1;
        @(posedge clk); #1;
        rst         = 1'b0;
        io.in_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_out_valid", {63'd0, io.out_valid}, 64'd0);
        check("rst_mid_sum", {32'd0, io.sum}, 64'd0);
        check("rst_mid_in_ready", {63'd0, io.in_ready}, 64'd1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (io.out_valid) cnt++;
        end
        check("rst_flush", 64'(cnt), 64'd0);

        send_one("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b1, OP_ADD, 32'h2345_678A,
                 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
